// File: rtl/gpu_result_reader.sv
// Read-back master: once every core is idle it streams the DIM x DIM result matrix out of RAM
// over valid/ready. It uses a 2-entry skid FIFO plus one in-flight read, so it sustains 1 element per cycle.
module gpu_result_reader #(
    parameter int DIM       = 16,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int ADDR_STEP = 4
) (
    input  logic                   CLK,
    input  logic                   RES,
    input  logic                   START,
    input  logic [3:0]             IDLE,
    input  logic [AW-1:0]          BASE,
    output logic [AW-1:0]          RADDR,
    output logic                   RWE,
    input  logic [DW-1:0]          RDATA,
    output logic                   OVALID,
    input  logic                   OREADY,
    output logic [DW-1:0]          ODATA,
    output logic [$clog2(DIM)-1:0] OROW,
    output logic [$clog2(DIM)-1:0] OCOL,
    output logic                   OLAST,
    output logic                   BUSY,
    output logic                   DONE
);
    localparam int NEL = DIM * DIM;
    localparam int IW  = $clog2(DIM);
    localparam int KW  = $clog2(NEL);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STREAM, S_DONE} state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   next_addr, raddr_q;
    logic [KW:0]     issue_cnt;
    logic            inflight;
    logic [KW-1:0]   inflight_k;
    logic [DW-1:0]   buf_data [2];
    logic [KW-1:0]   buf_k    [2];
    logic            rd_ptr, wr_ptr;
    logic [1:0]      count;
    logic [2:0]      occ;
    logic [KW-1:0]   head_k;
    logic            push, pop, issue;

    assign push   = inflight;
    assign OVALID = (count != 2'd0);
    assign pop    = OVALID & OREADY;
    assign head_k = buf_k[rd_ptr];
    assign ODATA  = buf_data[rd_ptr];
    assign OROW   = head_k[KW-1:IW];
    assign OCOL   = head_k[IW-1:0];
    assign OLAST  = OVALID && (head_k == KW'(NEL - 1));
    assign RWE    = 1'b0;
    assign BUSY   = (state != S_IDLE);

    // A slot freed by this cycle's pop may be refilled in the same cycle, which keeps the stream bubble-free.
    assign occ   = {1'b0, count} + {2'b00, inflight};
    assign issue = (state == S_STREAM) && (issue_cnt < (KW+1)'(NEL)) && (occ < 3'd2 + {2'b00, pop});
    assign RADDR = issue ? next_addr : raddr_q;

    always_comb begin
        state_nx = state;
        DONE     = 1'b0;
        case (state)
            S_IDLE:   if (START) state_nx = S_WAIT;
            S_WAIT:   if (IDLE == 4'hF) state_nx = S_STREAM;
            S_STREAM: if (pop && OLAST) state_nx = S_DONE;
            S_DONE: begin
                DONE     = 1'b1;
                state_nx = S_IDLE;
            end
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state      <= S_IDLE;
            next_addr  <= '0;
            raddr_q    <= '0;
            issue_cnt  <= '0;
            inflight   <= 1'b0;
            inflight_k <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_k[i]    <= '0;
            end
        end else begin
            state      <= state_nx;
            raddr_q    <= RADDR;
            inflight   <= issue;
            inflight_k <= issue_cnt[KW-1:0];
            if (state == S_IDLE && START) begin
                next_addr <= BASE;
                issue_cnt <= '0;
            end
            if (issue) begin
                next_addr <= next_addr + AW'(ADDR_STEP);
                issue_cnt <= issue_cnt + 1'b1;
            end
            // The element index rides with its data word so row/col always match ODATA.
            if (push) begin
                buf_data[wr_ptr] <= RDATA;
                buf_k[wr_ptr]    <= inflight_k;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule
